det_led_indicator: RTL and testbench

- Parametrised successor to the single-LED person indicator.
- Sits after the HOG/SVM classifier output (o_valid, is_person, sw_id) and drives NUM_LED board LEDs.
- Counts detections per frame and applies frame-level on/off hysteresis.
- Supports solid, blink, bar-graph and off display modes, and reports per-frame detection count.

---
 rtl/det_led_pkg.sv | 16 +
 rtl/blink_gen.sv | 43 ++++
 rtl/det_led_indicator.sv | 170 +++++++++++++++++
 tb/tb_det_led_indicator.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/det_led_pkg.sv
// Shared types and constants for the detection LED indicator.
package det_led_pkg;

    typedef enum logic [1:0] {
        OFF = 2'b00,
        ARM = 2'b01,
        ON  = 2'b10,
        REL = 2'b11
    } state_e;

    localparam logic [1:0] MODE_SOLID = 2'b00;
    localparam logic [1:0] MODE_BLINK = 2'b01;
    localparam logic [1:0] MODE_BAR   = 2'b10;
    localparam logic [1:0] MODE_OFF   = 2'b11;

endpackage

// File: rtl/blink_gen.sv
// Blink phase generator: toggles phase every BLINK_DIV enabled cycles and
// parks in the lit phase with a cleared counter while disabled.
module blink_gen #(
    parameter int BLINK_DIV = 25000000
) (
    input  logic clk,
    input  logic rst,
    input  logic en_i,
    output logic phase_o
);

    localparam int CW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    logic [CW-1:0] cnt_q, cnt_d;
    logic          phase_q, phase_d;

    always_comb begin
        cnt_d   = cnt_q;
        phase_d = phase_q;
        if (!en_i) begin
            cnt_d   = '0;
            phase_d = 1'b1;
        end else if (cnt_q == CW'(BLINK_DIV - 1)) begin
            cnt_d   = '0;
            phase_d = ~phase_q;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q   <= '0;
            phase_q <= 1'b1;
        end else begin
            cnt_q   <= cnt_d;
            phase_q <= phase_d;
        end
    end

    assign phase_o = phase_q;

endmodule

// File: rtl/det_led_indicator.sv
// Per-frame detection counter with on/off hysteresis driving a bank of LEDs
// in solid, blink, bar-graph or off display modes.
module det_led_indicator
    import det_led_pkg::*;
#(
    parameter int SW_W       = 11,
    parameter int NUM_SW     = 1200,
    parameter int CNT_W      = 8,
    parameter int MIN_HITS   = 1,
    parameter int ON_FRAMES  = 2,
    parameter int OFF_FRAMES = 3,
    parameter int NUM_LED    = 4,
    parameter int BLINK_DIV  = 25000000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               o_valid,
    input  logic               is_person,
    input  logic [SW_W-1:0]    sw_id,
    input  logic [1:0]         mode,
    output logic [NUM_LED-1:0] led,
    output logic [CNT_W-1:0]   det_count,
    output logic               frame_done
);

    localparam int RUN_MAX = (ON_FRAMES > OFF_FRAMES) ? ON_FRAMES : OFF_FRAMES;
    localparam int RUN_W   = $clog2(RUN_MAX + 1);

    logic               inc, last, hit;
    logic [CNT_W:0]     accSum;
    logic [CNT_W-1:0]   tot;
    logic [CNT_W-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0]   det_count_q, det_count_d;
    logic               frame_done_q;
    state_e             state_q, state_d;
    logic [RUN_W-1:0]   run_q, run_d, runInc;
    logic               active, phase;
    logic [NUM_LED-1:0] led_q, led_d;

    assign inc    = o_valid & is_person;
    assign last   = o_valid & (sw_id == SW_W'(NUM_SW - 1));
    assign runInc = run_q + 1'b1;

    // The closing beat's own decision is folded into the frame total.
    always_comb begin
        accSum      = {1'b0, acc_q} + {{CNT_W{1'b0}}, inc};
        tot         = accSum[CNT_W] ? '1 : accSum[CNT_W-1:0];
        acc_d       = last ? '0 : tot;
        det_count_d = last ? tot : det_count_q;
        hit         = (int'(tot) >= MIN_HITS);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q        <= '0;
            det_count_q  <= '0;
            frame_done_q <= 1'b0;
        end else begin
            acc_q        <= acc_d;
            det_count_q  <= det_count_d;
            frame_done_q <= last;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= OFF;
            run_q   <= '0;
        end else begin
            state_q <= state_d;
            run_q   <= run_d;
        end
    end

    always_comb begin
        state_d = state_q;
        run_d   = run_q;
        if (last) begin
            unique case (state_q)
                OFF: begin
                    if (hit) begin
                        if (ON_FRAMES == 1) begin
                            state_d = ON;
                            run_d   = '0;
                        end else begin
                            state_d = ARM;
                            run_d   = RUN_W'(1);
                        end
                    end
                end
                ARM: begin
                    if (!hit) begin
                        state_d = OFF;
                        run_d   = '0;
                    end else if (runInc == RUN_W'(ON_FRAMES)) begin
                        state_d = ON;
                        run_d   = '0;
                    end else begin
                        run_d = runInc;
                    end
                end
                ON: begin
                    if (!hit) begin
                        if (OFF_FRAMES == 1) begin
                            state_d = OFF;
                            run_d   = '0;
                        end else begin
                            state_d = REL;
                            run_d   = RUN_W'(1);
                        end
                    end
                end
                REL: begin
                    if (hit) begin
                        state_d = ON;
                        run_d   = '0;
                    end else if (runInc == RUN_W'(OFF_FRAMES)) begin
                        state_d = OFF;
                        run_d   = '0;
                    end else begin
                        run_d = runInc;
                    end
                end
                default: begin
                    state_d = OFF;
                    run_d   = '0;
                end
            endcase
        end
    end

    // Releasing still counts as lit so a short dropout does not flicker.
    always_comb begin
        active = (state_q == ON) || (state_q == REL);
        led_d  = '0;
        case (mode)
            MODE_SOLID: led_d = {NUM_LED{active}};
            MODE_BLINK: led_d = {NUM_LED{active & phase}};
            MODE_BAR: begin
                for (int i = 0; i < NUM_LED; i++) begin
                    led_d[i] = active && (int'(det_count_q) >= i + 1);
                end
            end
            MODE_OFF:   led_d = '0;
            default:    led_d = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            led_q <= '0;
        end else begin
            led_q <= led_d;
        end
    end

    blink_gen #(
        .BLINK_DIV(BLINK_DIV)
    ) u_blink (
        .clk    (clk),
        .rst    (rst),
        .en_i   (active),
        .phase_o(phase)
    );

    assign led        = led_q;
    assign det_count  = det_count_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_det_led_indicator.sv
// Bench for det_led_indicator: a frame-level model checked every cycle against
// a default-width instance and a 3-bit-counter instance, plus literal checks.
module tb_det_led_indicator;

    localparam int NUM_SW     = 8;
    localparam int BLINK_DIV  = 4;
    localparam int ON_FRAMES  = 2;
    localparam int OFF_FRAMES = 3;

    logic        clk       = 1'b0;
    logic        rst       = 1'b1;
    logic        o_valid   = 1'b0;
    logic        is_person = 1'b0;
    logic [10:0] sw_id     = '0;
    logic [1:0]  mode      = 2'b00;

    logic [3:0]  led;
    logic [7:0]  det_count;
    logic        frame_done;
    logic [3:0]  ledS;
    logic [2:0]  detCountS;
    logic        frameDoneS;

    int checks   = 0;
    int failures = 0;
    bit chkEn    = 1'b0;

    // Model state per instance: index 0 = 8-bit counter, 1 = 3-bit counter.
    int         mCnt[2];
    int         mDet[2];
    int         mStreak[2];
    int         mKk[2];
    bit         mOn[2];
    bit         mFd[2];
    logic [3:0] mLed[2];
    int         tot;
    int         maxc;
    bit         onBefore;
    bit         hit;

    det_led_indicator #(
        .NUM_SW(NUM_SW),
        .BLINK_DIV(BLINK_DIV)
    ) dut (
        .clk(clk), .rst(rst), .o_valid(o_valid), .is_person(is_person),
        .sw_id(sw_id), .mode(mode), .led(led), .det_count(det_count),
        .frame_done(frame_done)
    );

    det_led_indicator #(
        .NUM_SW(NUM_SW),
        .BLINK_DIV(BLINK_DIV),
        .CNT_W(3)
    ) dutSat (
        .clk(clk), .rst(rst), .o_valid(o_valid), .is_person(is_person),
        .sw_id(sw_id), .mode(mode), .led(ledS), .det_count(detCountS),
        .frame_done(frameDoneS)
    );

    always #5 clk = ~clk;

    function automatic logic [3:0] expectedLeds(bit on, logic [1:0] md, int det, int kk);
        logic [3:0] r;
        r = 4'b0000;
        case (md)
            2'b00: r = on ? 4'b1111 : 4'b0000;
            2'b01: r = (on && ((kk / BLINK_DIV) % 2 == 0)) ? 4'b1111 : 4'b0000;
            2'b10: for (int i = 0; i < 4; i++) r[i] = on && (det >= i + 1);
            default: r = 4'b0000;
        endcase
        return r;
    endfunction

    // Model: frame totals are min(raw count, counter max); hysteresis as streaks.
    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            maxc = (i == 0) ? 255 : 7;
            if (rst) begin
                mCnt[i] = 0; mDet[i] = 0; mStreak[i] = 0; mKk[i] = 0;
                mOn[i] = 1'b0; mFd[i] = 1'b0; mLed[i] = 4'b0000;
            end else begin
                mLed[i] = expectedLeds(mOn[i], mode, mDet[i], mKk[i]);
                onBefore = mOn[i];
                if (o_valid && is_person) mCnt[i]++;
                mFd[i] = 1'b0;
                if (o_valid && (int'(sw_id) == NUM_SW - 1)) begin
                    tot = (mCnt[i] > maxc) ? maxc : mCnt[i];
                    mDet[i] = tot;
                    mFd[i] = 1'b1;
                    mCnt[i] = 0;
                    hit = (tot >= 1);
                    if (!mOn[i]) begin
                        mStreak[i] = hit ? mStreak[i] + 1 : 0;
                        if (mStreak[i] == ON_FRAMES) begin
                            mOn[i] = 1'b1;
                            mStreak[i] = 0;
                        end
                    end else begin
                        mStreak[i] = hit ? 0 : mStreak[i] + 1;
                        if (mStreak[i] == OFF_FRAMES) begin
                            mOn[i] = 1'b0;
                            mStreak[i] = 0;
                        end
                    end
                end
                mKk[i] = (onBefore && mOn[i]) ? mKk[i] + 1 : 0;
            end
        end
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chkEn) begin
            checkOutput("model_led",         int'(led),        int'(mLed[0]));
            checkOutput("model_det_count",   int'(det_count),  mDet[0]);
            checkOutput("model_frame_done",  int'(frame_done), int'(mFd[0]));
            checkOutput("model_led_sat",     int'(ledS),       int'(mLed[1]));
            checkOutput("model_det_sat",     int'(detCountS),  mDet[1]);
            checkOutput("model_fd_sat",      int'(frameDoneS), int'(mFd[1]));
        end
    end

    task automatic applyStimulus(input logic r, input logic v, input logic p, input int id);
        @(negedge clk);
        rst       = r;
        o_valid   = v;
        is_person = p;
        sw_id     = 11'(id);
    endtask

    task automatic sendFrame(input logic [7:0] mask);
        for (int w = 0; w < 8; w++) applyStimulus(1'b0, 1'b1, mask[w], w);
        applyStimulus(1'b0, 1'b0, 1'b0, 0);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) applyStimulus(1'b0, 1'b0, 1'b0, 0);
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int pulses;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chkEn = 1'b1;
        checkOutput("reset_led", int'(led), 0);
        checkOutput("reset_det_count", int'(det_count), 0);
        applyStimulus(1'b0, 1'b0, 1'b0, 0);

        // Idle, including o_valid=0 beats that look like a last window.
        pulses = 0;
        for (int k = 0; k < 10; k++) begin
            applyStimulus(1'b0, 1'b0, 1'b1, 7);
            if (frame_done) pulses++;
        end
        checkOutput("idle_no_frame_done", pulses, 0);
        checkOutput("idle_led", int'(led), 0);

        // Two hit frames in solid mode turn the indicator on.
        mode = 2'b00;
        sendFrame(8'b0010_0100);
        checkOutput("f1_det_count", int'(det_count), 2);
        checkOutput("f1_frame_done", int'(frame_done), 1);
        idle(1);
        checkOutput("f1_fd_one_cycle", int'(frame_done), 0);
        checkOutput("f1_led_off", int'(led), 0);
        sendFrame(8'b0010_0100);
        checkOutput("f2_det_count", int'(det_count), 2);
        checkOutput("f2_led_not_yet", int'(led), 0);
        idle(1);
        checkOutput("f2_led_on", int'(led), 4'b1111);

        // Dropout of two frames, then recovery, then three empty frames.
        sendFrame(8'h00);
        sendFrame(8'h00);
        idle(1);
        checkOutput("rel_led_held", int'(led), 4'b1111);
        sendFrame(8'h10);
        idle(1);
        checkOutput("recover_led", int'(led), 4'b1111);
        sendFrame(8'h00);
        sendFrame(8'h00);
        sendFrame(8'h00);
        checkOutput("off_led_lag", int'(led), 4'b1111);
        idle(1);
        checkOutput("off_led", int'(led), 0);

        // Bar graph: turn on, then frames with 0, 1, 3 and 7 hits.
        sendFrame(8'h24);
        sendFrame(8'h24);
        mode = 2'b10;
        sendFrame(8'h00);
        idle(1);
        checkOutput("bar_0", int'(led), 4'b0000);
        sendFrame(8'h01);
        idle(1);
        checkOutput("bar_1", int'(led), 4'b0001);
        sendFrame(8'h07);
        idle(1);
        checkOutput("bar_3", int'(led), 4'b0111);
        sendFrame(8'h7F);
        idle(1);
        checkOutput("bar_7", int'(led), 4'b1111);
        mode = 2'b11;
        idle(1);
        checkOutput("mode_off", int'(led), 0);

        // Blink: fresh turn-on, first phase lit, 4-cycle half period.
        applyStimulus(1'b1, 1'b0, 1'b0, 0);
        applyStimulus(1'b0, 1'b0, 1'b0, 0);
        mode = 2'b01;
        sendFrame(8'h24);
        sendFrame(8'h24);
        for (int k = 0; k < 12; k++) begin
            idle(1);
            checkOutput("blink_pattern", int'(led), ((k / 4) % 2 == 0) ? 15 : 0);
        end

        // Reset mid-frame discards the partial count.
        for (int w = 0; w < 4; w++) applyStimulus(1'b0, 1'b1, 1'b1, w);
        applyStimulus(1'b1, 1'b0, 1'b0, 0);
        applyStimulus(1'b0, 1'b0, 1'b0, 0);
        checkOutput("midreset_led", int'(led), 0);
        checkOutput("midreset_det", int'(det_count), 0);
        sendFrame(8'h08);
        checkOutput("post_reset_det", int'(det_count), 1);

        // Saturation and out-of-range last index.
        mode = 2'b00;
        sendFrame(8'hFF);
        checkOutput("full_frame_det", int'(det_count), 8);
        checkOutput("sat_frame_det", int'(detCountS), 7);
        for (int w = 0; w < 7; w++) applyStimulus(1'b0, 1'b1, 1'b1, w);
        applyStimulus(1'b0, 1'b1, 1'b1, 9);
        applyStimulus(1'b0, 1'b0, 1'b1, 7);
        checkOutput("sw9_no_frame_end", int'(frame_done), 0);
        checkOutput("sw9_det_kept", int'(det_count), 8);
        applyStimulus(1'b0, 1'b1, 1'b1, 7);
        applyStimulus(1'b0, 1'b0, 1'b0, 0);
        checkOutput("sw9_frame_done", int'(frame_done), 1);
        checkOutput("sw9_det_count", int'(det_count), 9);
        checkOutput("sw9_det_sat", int'(detCountS), 7);
        idle(3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
